// File: rtl/gpr_pkg.sv
// Shared types and helpers for the general-purpose register file.
// Imported by the top and the scoreboard sub-module.
package gpr_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  typedef enum logic {
    GPR_IDLE,
    GPR_CLEAR
  } gpr_state_e;

  // Index width for a register count; a single-entry file still needs one bit.
  function automatic int gpr_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write tracker: decode allocates, writeback releases.
// A flush wipes every entry; rd_busy reports pending sources per read port.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG     = NREG_D,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = gpr_aw(NREG)
) (
  input  logic              wr_clk,
  input  logic              flush,
  input  logic              idle,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_reg,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_reg,
  input  logic [NRD*AW-1:0] rd_reg,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Release is applied before allocation so a same-cycle new producer wins.
  // Indices at or beyond NREG match no entry and are dropped.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (idle) begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en && (wr_reg == r[AW-1:0])) begin
          pending_d[r] = 1'b0;
        end
        if (alloc_en && (alloc_reg == r[AW-1:0])) begin
          pending_d[r] = 1'b1;
        end
      end
    end
    if (ZERO_REG) begin
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    pending_q <= pending_d;
  end

  // A write landing this cycle already satisfies the reader when it is forwarded.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 0; r < NREG; r++) begin
        if (rd_reg[p*AW +: AW] == r[AW-1:0]) begin
          rd_busy[p] = idle & pending_q[r]
                       & ~(BYPASS && wr_en && (wr_reg == r[AW-1:0]));
        end
      end
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-read-port GPR file with write-to-read bypass, pending-write scoreboard
// and a sequenced clear engine that zeroes one register per cycle.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int NREG     = NREG_D,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = gpr_aw(NREG)
) (
  input  logic                wr_clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_reg,
  input  logic [XLEN-1:0]     wr_bus,
  input  logic [NRD*AW-1:0]   rd_reg,
  output logic [NRD*XLEN-1:0] rd_bus,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_reg,
  input  logic                clr_req,
  output logic                clr_busy
);

  gpr_state_e      state_q;
  gpr_state_e      state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [AW-1:0]   clr_cnt_d;
  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] gpr_d [NREG];
  logic            idle;
  logic            clr_accept;

  assign idle       = (state_q == GPR_IDLE);
  assign clr_busy   = (state_q == GPR_CLEAR);
  assign clr_accept = idle & clr_req & ~rst;

  // Reset and accepted clear requests both restart the sweep from index 0.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (rst) begin
      state_d   = GPR_CLEAR;
      clr_cnt_d = '0;
    end else begin
      unique case (state_q)
        GPR_IDLE: begin
          if (clr_req) begin
            state_d   = GPR_CLEAR;
            clr_cnt_d = '0;
          end
        end
        GPR_CLEAR: begin
          if (clr_cnt_q == AW'(NREG - 1)) begin
            state_d   = GPR_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
          end
        end
        default: begin
          state_d   = GPR_CLEAR;
          clr_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge wr_clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
  end

  // The clear engine owns the array while active; writeback is locked out.
  always_comb begin
    gpr_d = gpr_q;
    for (int r = 0; r < NREG; r++) begin
      if (!rst && clr_busy && (clr_cnt_q == r[AW-1:0])) begin
        gpr_d[r] = '0;
      end else if (!rst && idle && wr_en && (wr_reg == r[AW-1:0])
                   && !(ZERO_REG && (r == 0))) begin
        gpr_d[r] = wr_bus;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    gpr_q <= gpr_d;
  end

  // Out-of-range indices and the hardwired zero register fall through to 0.
  always_comb begin
    rd_bus = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 0; r < NREG; r++) begin
        if (idle && (rd_reg[p*AW +: AW] == r[AW-1:0]) && !(ZERO_REG && (r == 0))) begin
          if (BYPASS && wr_en && (wr_reg == r[AW-1:0])) begin
            rd_bus[p*XLEN +: XLEN] = wr_bus;
          end else begin
            rd_bus[p*XLEN +: XLEN] = gpr_q[r];
          end
        end
      end
    end
  end

  gpr_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .wr_clk    (wr_clk),
    .flush     (rst | clr_accept),
    .idle      (idle),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg),
    .rd_reg    (rd_reg),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: a bypassing 32x32/2-port instance and a non-bypassing
// 16-entry/3-port instance share writeback/alloc stimulus and are checked side by side.
module tb_gpr_file_sb;

  logic        wr_clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_bus;
  logic        alloc_en;
  logic [4:0]  alloc_reg;
  logic        clr_req_a;

  logic [9:0]  rd_reg_a;
  logic [63:0] rd_bus_a;
  logic [1:0]  rd_busy_a;
  logic        clr_busy_a;

  logic [11:0] rd_reg_b;
  logic [95:0] rd_bus_b;
  logic [2:0]  rd_busy_b;
  logic        clr_busy_b;

  int n_cmp;
  int n_bad;
  int na;
  int nb;
  int nz;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wb;
    logic        ae;
    logic [4:0]  ar;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  ab;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [2:0]  bb;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];

  gpr_file_sb #(
    .XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_bus    (wr_bus),
    .rd_reg    (rd_reg_a),
    .rd_bus    (rd_bus_a),
    .rd_busy   (rd_busy_a),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg),
    .clr_req   (clr_req_a),
    .clr_busy  (clr_busy_a)
  );

  gpr_file_sb #(
    .XLEN(32), .NREG(16), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg[3:0]),
    .wr_bus    (wr_bus),
    .rd_reg    (rd_reg_b),
    .rd_bus    (rd_bus_b),
    .rd_busy   (rd_busy_b),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg[3:0]),
    .clr_req   (1'b0),
    .clr_busy  (clr_busy_b)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic we, input logic [4:0] wr,
                              input logic [31:0] wb, input logic ae, input logic [4:0] ar,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] ab,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                              input logic [2:0] bb);
    vec_t v;
    v.name = n; v.we = we; v.wr = wr; v.wb = wb; v.ae = ae; v.ar = ar;
    v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.a0 = a0; v.a1 = a1; v.ab = ab;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.bb = bb;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge wr_clk);
    #1;
    wr_en     = v.we;
    wr_reg    = v.wr;
    wr_bus    = v.wb;
    alloc_en  = v.ae;
    alloc_reg = v.ar;
    rd_reg_a  = {v.r1, v.r0};
    rd_reg_b  = {v.r2[3:0], v.r1[3:0], v.r0[3:0]};
    sb_q.push_back(v);
  endtask

  task automatic check_vector();
    vec_t e;
    @(negedge wr_clk);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check_output({e.name, "_a_bus0"}, rd_bus_a[31:0], e.a0);
      check_output({e.name, "_a_bus1"}, rd_bus_a[63:32], e.a1);
      check_output({e.name, "_a_busy"}, 32'(rd_busy_a), 32'(e.ab));
      check_output({e.name, "_b_bus0"}, rd_bus_b[31:0], e.b0);
      check_output({e.name, "_b_bus1"}, rd_bus_b[63:32], e.b1);
      check_output({e.name, "_b_bus2"}, rd_bus_b[95:64], e.b2);
      check_output({e.name, "_b_busy"}, 32'(rd_busy_b), 32'(e.bb));
    end
  endtask

  // Counts clear-busy cycles of both instances over a fixed window; nz counts
  // any nonzero read data or busy flag seen while an instance is clearing.
  task automatic count_clear(input int cycles, input int wr_stop, input int pulse_at,
                             output int ca, output int cb, output int cz);
    ca = 0; cb = 0; cz = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge wr_clk);
      if (clr_busy_a) begin
        ca++;
        if (rd_bus_a != '0 || rd_busy_a != '0) cz++;
      end
      if (clr_busy_b) begin
        cb++;
        if (rd_bus_b != '0 || rd_busy_b != '0) cz++;
      end
      @(posedge wr_clk);
      #1;
      if (i + 1 == wr_stop) begin
        wr_en    = 1'b0;
        alloc_en = 1'b0;
      end
      clr_req_a = (i + 1 == pulse_at);
    end
  endtask

  task automatic readback(input string tag);
    logic [4:0] ri;
    for (int r = 1; r < 32; r++) begin
      ri = 5'(r);
      @(posedge wr_clk);
      #1;
      rd_reg_a = {ri, ri};
      rd_reg_b = {ri[3:0], ri[3:0], ri[3:0]};
      @(negedge wr_clk);
      check_output($sformatf("%s_a_x%0d", tag, r), rd_bus_a[31:0] | rd_bus_a[63:32], 32'h0);
      check_output($sformatf("%s_a_busy_x%0d", tag, r), 32'(rd_busy_a), 32'h0);
      if (r < 16) begin
        check_output($sformatf("%s_b_x%0d", tag, r),
                     rd_bus_b[31:0] | rd_bus_b[63:32] | rd_bus_b[95:64], 32'h0);
        check_output($sformatf("%s_b_busy_x%0d", tag, r), 32'(rd_busy_b), 32'h0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_bus = '0;
    alloc_en = 1'b0; alloc_reg = '0; clr_req_a = 1'b0;
    rd_reg_a = {5'd5, 5'd3}; rd_reg_b = {4'd7, 4'd5, 4'd3};

    //               name              we  wr  wb            ae  ar  r0  r1  r2  a0            a1            ab     b0            b1            b2            bb
    vecs[0]  = mk("wr5_same_cycle",  1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 5, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[1]  = mk("rd5_array",       0, 0, 32'h0,        0, 0, 5, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3'b000);
    vecs[2]  = mk("wr0_dropped",     1, 0, 32'h1234,     0, 0, 0, 5, 0, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0,        32'hDEADBEEF, 32'h0,        3'b000);
    vecs[3]  = mk("rd0_after",       0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[4]  = mk("alloc7",          0, 0, 32'h0,        1, 7, 7, 7, 7, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[5]  = mk("wr7_while_busy",  1, 7, 32'h55,       0, 0, 7, 7, 7, 32'h55,       32'h55,       2'b00, 32'h0,        32'h0,        32'h0,        3'b111);
    vecs[6]  = mk("rd7_after",       0, 0, 32'h0,        0, 0, 7, 7, 7, 32'h55,       32'h55,       2'b00, 32'h55,       32'h55,       32'h55,       3'b000);
    vecs[7]  = mk("alloc_wr9",       1, 9, 32'hAA,       1, 9, 9, 9, 9, 32'hAA,       32'hAA,       2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[8]  = mk("rd9_pending",     0, 0, 32'h0,        0, 0, 9, 9, 9, 32'hAA,       32'hAA,       2'b11, 32'hAA,       32'hAA,       32'hAA,       3'b111);
    vecs[9]  = mk("realloc9",        0, 0, 32'h0,        1, 9, 9, 9, 9, 32'hAA,       32'hAA,       2'b11, 32'hAA,       32'hAA,       32'hAA,       3'b111);
    vecs[10] = mk("wr9_once",        1, 9, 32'hBB,       0, 0, 9, 3, 9, 32'hBB,       32'h0,        2'b00, 32'hAA,       32'h0,        32'hAA,       3'b101);
    vecs[11] = mk("rd9_released",    0, 0, 32'h0,        0, 0, 9, 9, 9, 32'hBB,       32'hBB,       2'b00, 32'hBB,       32'hBB,       32'hBB,       3'b000);
    vecs[12] = mk("alloc0",          0, 0, 32'h0,        1, 0, 0, 5, 5, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 3'b000);
    vecs[13] = mk("rd0_not_busy",    0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[14] = mk("wr3",             1, 3, 32'h11,       0, 0, 3, 3, 3, 32'h11,       32'h11,       2'b00, 32'h0,        32'h0,        32'h0,        3'b000);
    vecs[15] = mk("rd3",             0, 0, 32'h0,        0, 0, 3, 3, 3, 32'h11,       32'h11,       2'b00, 32'h11,       32'h11,       32'h11,       3'b000);

    repeat (3) @(posedge wr_clk);
    #1;
    check_output("reset_clr_busy_a", 32'(clr_busy_a), 32'h1);
    check_output("reset_clr_busy_b", 32'(clr_busy_b), 32'h1);
    check_output("reset_rd_bus_a", rd_bus_a[31:0] | rd_bus_a[63:32], 32'h0);
    check_output("reset_rd_busy_a", 32'(rd_busy_a), 32'h0);
    rst = 1'b0;

    count_clear(40, -1, -1, na, nb, nz);
    check_output("reset_clear_cycles_a", 32'(na), 32'd32);
    check_output("reset_clear_cycles_b", 32'(nb), 32'd16);
    check_output("reset_clear_nonzero", 32'(nz), 32'd0);
    readback("post_reset");

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_vector();
    end

    @(posedge wr_clk);
    #1;
    wr_en = 1'b0; alloc_en = 1'b1; alloc_reg = 5'd12;
    @(posedge wr_clk);
    #1;
    alloc_en = 1'b0; clr_req_a = 1'b1;
    rd_reg_a = {5'd3, 5'd12};
    @(negedge wr_clk);
    check_output("clr_accept_cycle_busy", 32'(clr_busy_a), 32'h0);
    check_output("alloc12_pending", 32'(rd_busy_a), 32'h1);
    check_output("clr_accept_cycle_x3", rd_bus_a[63:32], 32'h11);
    @(posedge wr_clk);
    #1;
    clr_req_a = 1'b0;
    wr_en = 1'b1; wr_reg = 5'd3; wr_bus = 32'hFF;
    alloc_en = 1'b1; alloc_reg = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      check_output($sformatf("clr_c%0d_busy", i), 32'(clr_busy_a), 32'h1);
      check_output($sformatf("clr_c%0d_bus", i), rd_bus_a[31:0] | rd_bus_a[63:32], 32'h0);
      check_output($sformatf("clr_c%0d_rd_busy", i), 32'(rd_busy_a), 32'h0);
      @(posedge wr_clk);
      #1;
    end
    rst = 1'b1;
    @(posedge wr_clk);
    #1;
    rst = 1'b0;
    count_clear(40, 8, -1, na, nb, nz);
    check_output("restart_clear_cycles_a", 32'(na), 32'd32);
    check_output("restart_clear_cycles_b", 32'(nb), 32'd16);
    check_output("restart_clear_nonzero", 32'(nz), 32'd0);
    readback("post_restart");

    @(posedge wr_clk);
    #1;
    clr_req_a = 1'b1;
    @(posedge wr_clk);
    #1;
    clr_req_a = 1'b0;
    count_clear(40, -1, 5, na, nb, nz);
    check_output("req_clear_cycles_a", 32'(na), 32'd32);
    check_output("req_clear_cycles_b", 32'(nb), 32'd0);
    check_output("req_clear_nonzero", 32'(nz), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
